// File: rtl/ts_pkg.sv
// Shared definitions for the multi-channel timestamp logger: entry word
// layout, edge-mode encodings and the entry packing helper.
package ts_pkg;

  localparam int unsigned TS_W      = 56;
  localparam int unsigned CHID_W    = 4;
  localparam int unsigned ENTRY_W   = 64;

  // Entry word field positions
  localparam int unsigned TS_LSB    = 8;
  localparam int unsigned CHID_LSB  = 4;
  localparam int unsigned LOST_BIT  = 3;
  localparam int unsigned LEVEL_BIT = 0;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [TS_W-1:0]   ts,
    input logic [CHID_W-1:0] id,
    input logic              lost,
    input logic              lvl
  );
    logic [ENTRY_W-1:0] e;
    e                     = '0;
    e[TS_LSB +: TS_W]     = ts;
    e[CHID_LSB +: CHID_W] = id;
    e[LOST_BIT]           = lost;
    e[LEVEL_BIT]          = lvl;
    return e;
  endfunction

endpackage

// File: rtl/ts_chan_front.sv
// Per-channel front end: synchroniser, agreement filter, edge qualification
// and the single-entry pending holder (timestamp, level, lost).
module ts_chan_front
  import ts_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            din_i,
  input  logic [1:0]      mode_i,
  input  logic [TS_W-1:0] counter_i,
  input  logic            edge_en_i,
  input  logic            init_rec_i,
  input  logic            grant_i,
  output logic            level_o,
  output logic            pending_o,
  output logic [TS_W-1:0] ts_o,
  output logic            lost_o,
  output logic            lvl_o,
  output logic            drop_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp;
  logic [3:0]             agree_q, agree_d;
  logic                   level_q, level_d;
  logic                   pend_q, pend_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   lost_q, lost_d;
  logic                   lvl_q, lvl_d;
  edge_mode_e             mode;
  logic                   chg, mode_hit, set_evt, drop;

  assign samp = sync_q[SYNC_STAGES-1];
  assign mode = edge_mode_e'(mode_i);

  // Filter: count consecutive samples disagreeing with the filtered level;
  // the FILT_LEN-th one (the current sample included) flips the level
  always_comb begin
    level_d = level_q;
    agree_d = '0;
    if (samp != level_q) begin
      if (agree_q == 4'(FILT_LEN - 1)) level_d = samp;
      else                             agree_d = agree_q + 4'd1;
    end
  end

  // Edge qualification against the configured polarity
  always_comb begin
    mode_hit = 1'b0;
    unique case (mode)
      EDGE_OFF:  mode_hit = 1'b0;
      EDGE_RISE: mode_hit = level_d;
      EDGE_FALL: mode_hit = !level_d;
      EDGE_BOTH: mode_hit = 1'b1;
    endcase
  end

  assign chg     = (level_d != level_q);
  assign set_evt = (edge_en_i && chg && mode_hit) || (init_rec_i && (mode != EDGE_OFF));
  assign drop    = set_evt && pend_q && !grant_i;

  // Pending holder: grant clears, a new event sets and overwrites; an event
  // arriving while an ungranted entry is held marks it lost
  always_comb begin
    pend_d = pend_q;
    ts_d   = ts_q;
    lost_d = lost_q;
    lvl_d  = lvl_q;
    if (grant_i) pend_d = 1'b0;
    if (set_evt) begin
      pend_d = 1'b1;
      ts_d   = counter_i;
      lvl_d  = level_d;
      lost_d = drop;
    end
  end

  // Synchroniser, filter and pending state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      agree_q <= '0;
      level_q <= 1'b0;
      pend_q  <= 1'b0;
      ts_q    <= '0;
      lost_q  <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      agree_q <= agree_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      ts_q    <= ts_d;
      lost_q  <= lost_d;
      lvl_q   <= lvl_d;
    end
  end

  assign level_o   = level_q;
  assign pending_o = pend_q;
  assign ts_o      = ts_q;
  assign lost_o    = lost_q;
  assign lvl_o     = lvl_q;
  assign drop_o    = drop;

endmodule

// File: rtl/ts_fifo.sv
// Pointer FIFO with show-ahead head output. A written entry becomes visible
// to the read side (empty/head) one clock after the push; full is judged
// against the real write pointer. Pop and push in one cycle are both
// honoured, including when full.
module ts_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, vis_q, rd_q, rd_d;
  logic             do_pop, do_push;

  assign empty_o = (vis_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pointer registers; vis_q trails wr_q by one clock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      vis_q <= '0;
      rd_q  <= '0;
    end else begin
      wr_q  <= wr_d;
      vis_q <= wr_q;
      rd_q  <= rd_d;
    end
  end

  // Storage array, contents discarded logically by the pointer reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ts_multichannel.sv
// Multi-channel timestamp event logger: NCH filtered, edge-qualified inputs
// feed a round-robin arbiter into one shared FIFO read byte-wise.
// Optional TS_INIT_RECORD_EN: after the settle window every enabled channel
// records its initial filtered level once.
module ts_multichannel
  import ts_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH-1:0]    datain,
  input  logic [2*NCH-1:0]  edge_mode,
  input  logic [TS_W-1:0]   counterin,
  input  logic              unload,
  input  logic [2:0]        byteaddr,
  output logic [7:0]        dataout,
  input  logic              clearoverrun,
  output logic              overrun,
  output logic [15:0]       drop_count,
  output logic              attention,
  output logic [NCH-1:0]    level
);

  localparam int unsigned SETTLE = SYNC_STAGES + FILT_LEN + 1;

  logic [4:0]         settle_q, settle_d;
  logic               edge_en, init_fire;
  logic [NCH-1:0]     pend, gnt, drop;
  logic [TS_W-1:0]    ch_ts [NCH];
  logic [NCH-1:0]     ch_lost, ch_lvl;
  logic               found;
  logic [CHID_W-1:0]  gidx, p_q, p_d;
  logic [ENTRY_W-1:0] push_entry, head;
  logic               fifo_empty, fifo_full;
  logic [4:0]         ndrop;
  logic [16:0]        cnt_sum;
  logic [15:0]        drop_count_q, drop_count_d;
  logic               overrun_q, overrun_d, attention_q;

  // Settle window counter: edges masked until it saturates
  assign settle_d = (settle_q == 5'(SETTLE)) ? settle_q : settle_q + 5'd1;
  assign edge_en  = (settle_q == 5'(SETTLE));
`ifdef TS_INIT_RECORD_EN
  assign init_fire = (settle_q == 5'(SETTLE - 1));
`else
  assign init_fire = 1'b0;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    ts_chan_front #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_front (
      .clk        (clk),
      .rstn       (rstn),
      .din_i      (datain[gi]),
      .mode_i     (edge_mode[2*gi +: 2]),
      .counter_i  (counterin),
      .edge_en_i  (edge_en),
      .init_rec_i (init_fire),
      .grant_i    (gnt[gi]),
      .level_o    (level[gi]),
      .pending_o  (pend[gi]),
      .ts_o       (ch_ts[gi]),
      .lost_o     (ch_lost[gi]),
      .lvl_o      (ch_lvl[gi]),
      .drop_o     (drop[gi])
    );
  end

  // Round-robin grant: search indices >= p first, then wrap to the lowest
  always_comb begin
    found      = 1'b0;
    gidx       = '0;
    gnt        = '0;
    push_entry = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!found && pend[i] && (i >= 32'(p_q))) begin
          found = 1'b1;
          gidx  = CHID_W'(i);
        end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!found && pend[i]) begin
          found = 1'b1;
          gidx  = CHID_W'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (found && (gidx == CHID_W'(i))) begin
        gnt[i]     = 1'b1;
        push_entry = pack_entry(ch_ts[i], CHID_W'(i), ch_lost[i], ch_lvl[i]);
      end
    end
  end

  // Pointer advances past the granted channel
  always_comb begin
    p_d = p_q;
    if (found) p_d = (gidx == CHID_W'(NCH - 1)) ? '0 : gidx + CHID_W'(1);
  end

  // Drop accounting: a drop in the clear cycle survives the clear
  always_comb begin
    ndrop = '0;
    for (int unsigned i = 0; i < NCH; i++) ndrop = ndrop + 5'(drop[i]);
    cnt_sum      = {1'b0, (clearoverrun ? 16'd0 : drop_count_q)} + 17'(ndrop);
    drop_count_d = cnt_sum[16] ? '1 : cnt_sum[15:0];
    overrun_d    = (clearoverrun ? 1'b0 : overrun_q) | (ndrop != 5'd0);
  end

  // Status and arbiter state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      settle_q     <= '0;
      p_q          <= '0;
      drop_count_q <= '0;
      overrun_q    <= 1'b0;
      attention_q  <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      p_q          <= p_d;
      drop_count_q <= drop_count_d;
      overrun_q    <= overrun_d;
      attention_q  <= !fifo_empty || overrun_q;
    end
  end

  ts_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (found),
    .din_i   (push_entry),
    .pop_i   (unload),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Byte select of the head entry
  always_comb begin
    dataout = '0;
    if (!fifo_empty) dataout = head[{byteaddr, 3'b000} +: 8];
  end

  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;
  assign attention  = attention_q;

endmodule

// File: tb/tb_ts_multichannel.sv
// Directed bench for ts_multichannel (NCH=4, FILT_LEN=3, SYNC_STAGES=2,
// FIFO_DEPTH=16). All stimulus changes on the falling clock edge.
module tb_ts_multichannel;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  datain = '0;
  logic [7:0]  edge_mode = '0;
  logic [55:0] counterin = '0;
  logic        unload = 1'b0;
  logic [2:0]  byteaddr = '0;
  logic [7:0]  dataout;
  logic        clearoverrun = 1'b0;
  logic        overrun;
  logic [15:0] drop_count;
  logic        attention;
  logic [3:0]  level;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #10 clk = ~clk;

  ts_multichannel #(
    .NCH         (4),
    .FILT_LEN    (3),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .datain       (datain),
    .edge_mode    (edge_mode),
    .counterin    (counterin),
    .unload       (unload),
    .byteaddr     (byteaddr),
    .dataout      (dataout),
    .clearoverrun (clearoverrun),
    .overrun      (overrun),
    .drop_count   (drop_count),
    .attention    (attention),
    .level        (level)
  );

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      counterin = counterin + 56'd1;
    end
  endtask

  task automatic read_head(output logic [63:0] e);
    e = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      byteaddr = 3'(b);
      #1;
      e[8*b +: 8] = dataout;
    end
    byteaddr = '0;
    #1;
  endtask

  task automatic pop;
    unload = 1'b1;
    tick(1);
    unload = 1'b0;
  endtask

  task automatic apply_reset(input logic [3:0] v);
    datain = v;
    rstn   = 1'b0;
    tick(2);
    rstn   = 1'b1;
    tick(12);
  endtask

  task automatic test_reset;
    logic [63:0] e;
    logic [7:0]  exp8;
    edge_mode = 8'h55;
    datain    = 4'b0101;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL reset_dataout: got %0h expected 0", dataout); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop_count: got %0h expected 0", drop_count); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL reset_attention: got %0b expected 0", attention); end
    n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %0b expected 0000", level); end
    tick(2);
    rstn = 1'b1;
    tick(12);
    n_checks++; if (level !== 4'b0101) begin n_fail++; $display("FAIL settle_level: got %0b expected 0101", level); end
`ifdef TS_INIT_RECORD_EN
    for (int unsigned k = 0; k < 4; k++) begin
      read_head(e);
      exp8 = {4'(k), 3'b000, ~k[0]};
      n_checks++; if (e[7:0] !== exp8) begin n_fail++; $display("FAIL init_entry%0d: got %0h expected %0h", k, e[7:0], exp8); end
      pop();
    end
`else
    e    = '0;
    exp8 = '0;
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL settle_no_entry_attention: got %0b expected 0", attention); end
    n_checks++; if (dataout !== exp8) begin n_fail++; $display("FAIL settle_no_entry_dataout: got %0h expected %0h", dataout, exp8); end
`endif
  endtask

  task automatic test_single_edge;
    logic [63:0] e;
    edge_mode = 8'h00;
    apply_reset(4'b0000);
    edge_mode = 8'b0000_0011;
    datain    = 4'b0001;
    counterin = 56'hFC;
    tick(4);
    n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL single_level_early: got %0b expected 0000", level); end
    tick(1);
    n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL single_level_change: got %0b expected 0001", level); end
    tick(1);
    n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL single_dataout_early: got %0h expected 0", dataout); end
    tick(1);
    n_checks++; if (dataout !== 8'h01) begin n_fail++; $display("FAIL single_dataout_visible: got %0h expected 01", dataout); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL single_attention_early: got %0b expected 0", attention); end
    tick(1);
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL single_attention: got %0b expected 1", attention); end
    read_head(e);
    n_checks++; if (e !== {56'h100, 4'h0, 4'h1}) begin n_fail++; $display("FAIL single_entry: got %016h expected %016h", e, {56'h100, 4'h0, 4'h1}); end
    pop();
    n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL single_pop_dataout: got %0h expected 0", dataout); end
    tick(1);
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL single_pop_attention: got %0b expected 0", attention); end
  endtask

  task automatic test_glitch;
    edge_mode = 8'b0000_1100;
    datain    = 4'b0010;
    tick(2);
    datain    = 4'b0000;
    tick(10);
    n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL glitch_level: got %0b expected 0000", level); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL glitch_attention: got %0b expected 0", attention); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    logic [63:0] exp;
    edge_mode = 8'h00;
    apply_reset(4'b0000);
    edge_mode = 8'hFF;
    datain    = 4'hF;
    counterin = 56'h2FC;
    tick(7);
    n_checks++; if (dataout !== 8'h01) begin n_fail++; $display("FAIL b2b_first_head: got %0h expected 01", dataout); end
    tick(3);
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL b2b_attention: got %0b expected 1", attention); end
    for (int unsigned k = 0; k < 4; k++) begin
      read_head(e);
      exp = {56'h300, 4'(k), 4'h1};
      n_checks++; if (e !== exp) begin n_fail++; $display("FAIL b2b_entry%0d: got %016h expected %016h", k, e, exp); end
      pop();
    end
    n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL b2b_drained: got %0h expected 0", dataout); end
  endtask

  task automatic test_fifo_full;
    logic [63:0] e;
    logic [7:0]  exp8;
    edge_mode = 8'hFF;
    for (int unsigned j = 0; j < 4; j++) begin
      datain = j[0] ? 4'hF : 4'h0;
      tick(10);
    end
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL full_attention: got %0b expected 1", attention); end
    datain = 4'b1011;
    tick(10);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL full_first_edge_overrun: got %0b expected 0", overrun); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL full_first_edge_drops: got %0d expected 0", drop_count); end
    counterin = 56'h4FFC;
    datain    = 4'hF;
    tick(4);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL full_overrun_early: got %0b expected 0", overrun); end
    tick(1);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL full_overrun: got %0b expected 1", overrun); end
    n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 1", drop_count); end
    for (int unsigned k = 0; k < 16; k++) begin
      exp8 = {4'(k % 4), 3'b000, 1'((k / 4) % 2)};
      n_checks++; if (dataout !== exp8) begin n_fail++; $display("FAIL full_order%0d: got %0h expected %0h", k, dataout, exp8); end
      pop();
    end
    read_head(e);
    n_checks++; if (e !== {56'h5000, 4'h2, 4'b1001}) begin n_fail++; $display("FAIL full_lost_entry: got %016h expected %016h", e, {56'h5000, 4'h2, 4'b1001}); end
    pop();
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL full_attention_overrun: got %0b expected 1", attention); end
    clearoverrun = 1'b1;
    tick(1);
    clearoverrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clear_overrun: got %0b expected 0", overrun); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL clear_drop_count: got %0d expected 0", drop_count); end
    tick(1);
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL clear_attention: got %0b expected 0", attention); end
  endtask

  task automatic test_mode_polarity;
    logic [63:0] e;
    edge_mode = 8'b0100_0000;
    datain    = 4'b0111;
    tick(10);
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL rise_mode_fall_attention: got %0b expected 0", attention); end
    n_checks++; if (level !== 4'b0111) begin n_fail++; $display("FAIL rise_mode_fall_level: got %0b expected 0111", level); end
    edge_mode = 8'b1000_0000;
    datain    = 4'hF;
    tick(10);
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL fall_mode_rise_attention: got %0b expected 0", attention); end
    counterin = 56'h6FFC;
    datain    = 4'b0111;
    tick(7);
    n_checks++; if (dataout !== 8'h30) begin n_fail++; $display("FAIL fall_mode_head: got %0h expected 30", dataout); end
    tick(1);
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL fall_mode_attention: got %0b expected 1", attention); end
    read_head(e);
    n_checks++; if (e !== {56'h7000, 4'h3, 4'h0}) begin n_fail++; $display("FAIL fall_mode_entry: got %016h expected %016h", e, {56'h7000, 4'h3, 4'h0}); end
    rstn = 1'b0;
    #1;
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL midreset_attention: got %0b expected 0", attention); end
    n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL midreset_dataout: got %0h expected 0", dataout); end
    tick(2);
    rstn = 1'b1;
    tick(12);
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL midreset_after_attention: got %0b expected 0", attention); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_glitch();
    test_back_to_back();
    test_fifo_full();
    test_mode_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
